aes_key_expander: RTL
=====================

AES_KEY_EXPANDER -- requirements
Module: aes_key_expander

Interface
REQ-001 SHALL have parameter NR, default 10, meaning number of AES rounds; only 10 (AES-128) is supported.
REQ-002 SHALL have parameter NK, default 4, meaning cipher key length in 32-bit words; only 4 is supported.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: request to expand key_in.
REQ-006 SHALL have port key_in, input, 128 bits [0:127]: cipher key, byte 0 at bits [0:7].
REQ-007 SHALL have port rd_idx, input, 4 bits: round-key index to read, range 0..10.
REQ-008 SHALL have port rd_key, output, 128 bits [0:127]: round key selected by rd_idx.
REQ-009 SHALL have port busy, output, 1 bit: high while expansion is in progress.
REQ-010 SHALL have port done, output, 1 bit: one-cycle pulse when all round keys are stored.
REQ-011 SHALL have port key_valid, output, 1 bit: level, high while the stored schedule is complete and current.

Function
REQ-012 SHALL implement states IDLE, EXPAND and READY.
REQ-013 SHALL, in IDLE or READY with start=1 at edge T, write key_in to rk[0], set the round counter to 1, enter EXPAND, set busy=1, and clear key_valid.
REQ-014 SHALL, in EXPAND, write one key per edge: rk[i] from rk[i-1] per FIPS-197 (RotWord, SubWord, XOR Rcon[i] into word 0, then chained XOR of words 1..3), then increment i.
REQ-015 SHALL write rk[10] at edge T+10, and from that edge enter READY with busy=0, key_valid=1 and done=1 for exactly one cycle.
REQ-016 SHALL ignore start while in EXPAND; the expansion in progress SHALL finish unchanged.
REQ-017 SHALL accept start in READY (restart); done SHALL NOT pulse again until the new rk[10] is written.
REQ-018 SHALL sample key_in only at the start edge; later changes to key_in SHALL have no effect.
REQ-019 SHALL drive rd_key combinationally as rk[rd_idx] for rd_idx 0..10 and as all-zero for rd_idx 11..15.
REQ-020 SHALL allow rd_key reads in any state; keys not yet rewritten keep their previous values, and consumers SHALL qualify reads with key_valid.
REQ-021 SHALL make Rcon[1..10] = 01,02,04,08,10,20,40,80,1B,36 (hex), applied to the most-significant byte of word 0.

Reset
REQ-022 SHALL, with rst=1 at an edge, enter IDLE with busy=0, done=0, key_valid=0 and round counter 0; rst SHALL take priority over start.
REQ-023 SHALL clear all rk[0..10] to zero on reset, so rd_key reads zero after reset.
REQ-024 SHALL, on reset during EXPAND, abandon the expansion with no done pulse.

Structure
REQ-025 SHALL place NR, NK and the Rcon table in a shared AES package used by the encrypt and decrypt paths.
REQ-026 SHALL use the single sub-module aes_sbox (8-bit forward S-box, combinational), instantiated 4 times for SubWord.
REQ-027 SHALL hold the 11x128-bit round-key store in flops (no RAM), with one expansion datapath reused each cycle.

Verification
REQ-028 SHALL pass this test: key 2b7e151628aed2a6abf7158809cf4f3c, start -> done exactly 10 cycles later; rk[1]=a0fafe1788542cb123a339392a6c7605; rk[10]=d014f9a8c9ee2589e13f0cc8b6630ca6.
REQ-029 SHALL pass this test: restart from READY with key 000...0 -> key_valid low during expansion; rk[1]=62636363 repeated 4 times; rk[10]=b4ef5bcb3e92e21123e951cf6f8f188e.
REQ-030 SHALL pass this test: start pulsed again at T+4 with a different key -> ignored, and results are identical to the FIPS-197 vectors above.
REQ-031 SHALL pass this test: rst asserted at T+5 -> IDLE next cycle, busy=0, no done pulse, rd_key=0 for all indices.
REQ-032 SHALL pass this test: rd_idx=11..15 in READY -> rd_key=0; rd_idx=0 -> the captured key_in.
REQ-033 SHALL pass this test: start and rst both high on the same edge -> IDLE, busy=0, key_valid=0.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES definitions used by the key expander and by the encrypt and
// decrypt datapaths.
//   AES_NR / AES_NK : round count and key length in 32-bit words (AES-128).
//   kx_state_t      : key-expander control states.
//   aes_rcon()      : round constant table Rcon[1..10], MSB byte of word 0.
package aes_pkg;

    localparam int AES_NR = 10;
    localparam int AES_NK = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXPAND,
        ST_READY
    } kx_state_t;

    // Round constants; index 0 and 11..15 never occur during expansion.
    function automatic logic [7:0] aes_rcon(input logic [3:0] round);
        logic [7:0] rc;
        case (round)
            4'd1:    rc = 8'h01;
            4'd2:    rc = 8'h02;
            4'd3:    rc = 8'h04;
            4'd4:    rc = 8'h08;
            4'd5:    rc = 8'h10;
            4'd6:    rc = 8'h20;
            4'd7:    rc = 8'h40;
            4'd8:    rc = 8'h80;
            4'd9:    rc = 8'h1b;
            4'd10:   rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Forward AES S-box, purely combinational.
//   value : input byte
//   subst : substituted byte S(value)
module aes_sbox (
    input  logic [7:0] value,
    output logic [7:0] subst
);

    // Entry for byte x lives at bits [2047-8x -: 8] (entry 0 is the MSB byte).
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign subst = SBOX_TABLE[11'd2047 - {value, 3'b000} -: 8];

endmodule

// File: rtl/aes_key_expander.sv
// AES-128 key schedule generator. One round key is produced per clock by a
// single shared expansion datapath; all 11 round keys are kept in flops.
//   clk       : clock, rising edge
//   rst       : synchronous active-high reset (clears schedule, wins over start)
//   start     : capture key_in and expand (ignored while expanding)
//   key_in    : cipher key, byte 0 at bits [0:7]
//   rd_idx    : round key to read (0..10; 11..15 read as zero)
//   rd_key    : combinational read of the selected round key
//   busy      : expansion in progress
//   done      : one-cycle pulse once rk[10] has been written
//   key_valid : stored schedule is complete and matches the last captured key
module aes_key_expander
    import aes_pkg::*;
#(
    parameter int NR = AES_NR,
    parameter int NK = AES_NK
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [0:127] key_in,
    input  logic [3:0]   rd_idx,
    output logic [0:127] rd_key,
    output logic         busy,
    output logic         done,
    output logic         key_valid
);

    localparam logic [3:0] LAST_ROUND = 4'(NR);

    kx_state_t    state_reg, state_next;
    logic [3:0]   round_reg, round_next;
    logic         done_reg, done_next;
    logic [0:127] rk_reg [0:NR];

    logic         load;
    logic [NR:0]  rk_we;
    logic [0:127] prev_key;
    logic [0:127] next_key;
    logic [0:31]  w_prev [0:NK-1];
    logic [0:31]  w_new  [0:NK-1];
    logic [0:31]  rot_word;
    logic [0:31]  sub_word;
    logic [0:31]  temp_word;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            round_reg <= 4'd0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            round_reg <= round_next;
            done_reg  <= done_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        round_next = round_reg;
        done_next  = 1'b0;
        case (state_reg)
            ST_IDLE, ST_READY: begin
                if (start) begin
                    state_next = ST_EXPAND;
                    round_next = 4'd1;
                end
            end
            ST_EXPAND: begin
                if (round_reg == LAST_ROUND) begin
                    state_next = ST_READY;
                    round_next = 4'd0;
                    done_next  = 1'b1;
                end else begin
                    round_next = round_reg + 4'd1;
                end
            end
            default: begin
                state_next = ST_IDLE;
                round_next = 4'd0;
            end
        endcase
    end

    assign load      = start && (state_reg != ST_EXPAND);
    assign busy      = (state_reg == ST_EXPAND);
    assign key_valid = (state_reg == ST_READY);
    assign done      = done_reg;

    // ------------------------------------------------------------------
    // Expansion datapath: rk[i] = f(rk[i-1]) with i = round_reg
    // ------------------------------------------------------------------
    always_comb begin
        prev_key = '0;
        if (round_reg != 4'd0 && round_reg <= LAST_ROUND) begin
            prev_key = rk_reg[round_reg - 4'd1];
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NK; gi++) begin : g_split
            assign w_prev[gi] = prev_key[32*gi +: 32];
        end
    endgenerate

    // RotWord on the last word of the previous key
    assign rot_word = {w_prev[NK-1][8:31], w_prev[NK-1][0:7]};

    generate
        for (gi = 0; gi < 4; gi++) begin : g_subword
            aes_sbox u_sbox (
                .value (rot_word[8*gi +: 8]),
                .subst (sub_word[8*gi +: 8])
            );
        end
    endgenerate

    assign temp_word = sub_word ^ {aes_rcon(round_reg), 24'h000000};

    // Word 0 takes the transformed word; each later word chains off its
    // freshly computed predecessor.
    generate
        for (gi = 0; gi < NK; gi++) begin : g_chain
            if (gi == 0) begin : g_first
                assign w_new[gi] = w_prev[gi] ^ temp_word;
            end else begin : g_rest
                assign w_new[gi] = w_new[gi-1] ^ w_prev[gi];
            end
            assign next_key[32*gi +: 32] = w_new[gi];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Round-key store
    // ------------------------------------------------------------------
    generate
        for (gi = 0; gi <= NR; gi++) begin : g_we
            if (gi == 0) begin : g_key0
                assign rk_we[gi] = load;
            end else begin : g_keyn
                assign rk_we[gi] = (state_reg == ST_EXPAND) && (round_reg == 4'(gi));
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        for (int i = 0; i <= NR; i++) begin
            if (rst) begin
                rk_reg[i] <= '0;
            end else if (rk_we[i]) begin
                rk_reg[i] <= (i == 0) ? key_in : next_key;
            end
        end
    end

    always_comb begin
        rd_key = '0;
        if (rd_idx <= LAST_ROUND) begin
            rd_key = rk_reg[rd_idx];
        end
    end

endmodule
